ven_machine: RTL and testbench

Coin-operated vending controller for a single product priced at 15 units. It accepts one coin per clock as a 2-bit code (5 or 10 units) and accumulates credit in a 3-state FSM. When credit reaches or exceeds the price, it pulses a one-cycle vend and any change. A cycle with no coin while credit is held is a cancel: the held credit is refunded.

---
 rtl/ven_machine_pkg.sv | 22 ++
 rtl/ven_machine.sv | 71 +++++++
 tb/tb_ven_machine.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/ven_machine_pkg.sv
// Shared types and code constants for the single-product vending controller.
package ven_machine_pkg;

  localparam int unsigned COIN_W  = 2;
  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    S0  = 2'b00,
    S5  = 2'b01,
    S10 = 2'b10
  } state_e;

  localparam logic [COIN_W-1:0] COIN_NONE = 2'b00;
  localparam logic [COIN_W-1:0] COIN_5    = 2'b01;
  localparam logic [COIN_W-1:0] COIN_10   = 2'b10;
  localparam logic [COIN_W-1:0] COIN_BAD  = 2'b11;

  localparam logic [COIN_W-1:0] CHG_NONE = 2'b00;
  localparam logic [COIN_W-1:0] CHG_5    = 2'b01;
  localparam logic [COIN_W-1:0] CHG_10   = 2'b10;

endpackage

// File: rtl/ven_machine.sv
// Vending controller: accumulates 5/10 coins toward a price of 15, pulses vend
// and change from flops, refunds held credit on an idle cycle.
module ven_machine
  import ven_machine_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [COIN_W-1:0] in,
  output logic              out,
  output logic [COIN_W-1:0] change
);

  state_e            c_state;
  state_e            nxt_state;
  logic              out_nxt;
  logic [COIN_W-1:0] change_nxt;

  // State and output registers; reset discards held credit without refund.
  always_ff @(posedge clk) begin
    if (rst) begin
      c_state <= S0;
      out     <= 1'b0;
      change  <= CHG_NONE;
    end else begin
      c_state <= nxt_state;
      out     <= out_nxt;
      change  <= change_nxt;
    end
  end

  // Next-state and output decode; any unlisted combination falls back to S0 with no outputs.
  always_comb begin
    nxt_state  = S0;
    out_nxt    = 1'b0;
    change_nxt = CHG_NONE;
    case (c_state)
      S0: begin
        case (in)
          COIN_NONE: nxt_state = S0;
          COIN_5:    nxt_state = S5;
          COIN_10:   nxt_state = S10;
          COIN_BAD:  nxt_state = S0;
          default:   nxt_state = S0;
        endcase
      end
      S5: begin
        case (in)
          COIN_NONE: change_nxt = CHG_5;
          COIN_5:    nxt_state  = S10;
          COIN_10:   out_nxt    = 1'b1;
          COIN_BAD:  nxt_state  = S5;
          default:   nxt_state  = S0;
        endcase
      end
      S10: begin
        case (in)
          COIN_NONE: change_nxt = CHG_10;
          COIN_5:    out_nxt    = 1'b1;
          COIN_10: begin
            out_nxt    = 1'b1;
            change_nxt = CHG_5;
          end
          COIN_BAD:  nxt_state  = S10;
          default:   nxt_state  = S0;
        endcase
      end
      default: nxt_state = S0;
    endcase
  end

endmodule

// File: tb/tb_ven_machine.sv
// Scoreboard bench for ven_machine: driver queues expected state/outputs per edge,
// monitor checks them just after each rising edge.
module tb_ven_machine;

  logic       clk;
  logic       rst;
  logic [1:0] in;
  logic       out;
  logic [1:0] change;

  typedef struct {
    string      name;
    logic [1:0] st;
    logic       vend;
    logic [1:0] chg;
  } exp_t;

  exp_t exp_q[$];
  int   total;
  int   bad;

  ven_machine dut (
    .clk    (clk),
    .rst    (rst),
    .in     (in),
    .out    (out),
    .change (change)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input string name, input logic r, input logic [1:0] coin,
                      input logic [1:0] st, input logic vend, input logic [1:0] chg);
    exp_t e;
    @(negedge clk);
    rst = r;
    in  = coin;
    e.name = name;
    e.st   = st;
    e.vend = vend;
    e.chg  = chg;
    exp_q.push_back(e);
  endtask

  // Monitor: every rising edge whose response is queued gets checked.
  initial begin
    exp_t e;
    logic [1:0] st_act;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        st_act = 2'(dut.c_state);
        total++;
        if (st_act !== e.st) begin
          bad++;
          $display("FAIL %s c_state: got %b want %b", e.name, st_act, e.st);
        end
        total++;
        if (out !== e.vend) begin
          bad++;
          $display("FAIL %s out: got %b want %b", e.name, out, e.vend);
        end
        total++;
        if (change !== e.chg) begin
          bad++;
          $display("FAIL %s change: got %b want %b", e.name, change, e.chg);
        end
      end
    end
  end

  initial begin
    int wait_cyc;
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    in    = 2'b00;

    step("reset",       1'b1, 2'b00, 2'b00, 1'b0, 2'b00);
    step("idle0",       1'b0, 2'b00, 2'b00, 1'b0, 2'b00);
    step("idle1",       1'b0, 2'b00, 2'b00, 1'b0, 2'b00);

    step("f5_a",        1'b0, 2'b01, 2'b01, 1'b0, 2'b00);
    step("f5_b",        1'b0, 2'b01, 2'b10, 1'b0, 2'b00);
    step("f5_vend",     1'b0, 2'b01, 2'b00, 1'b1, 2'b00);
    step("f5_after",    1'b0, 2'b00, 2'b00, 1'b0, 2'b00);

    step("t10_a",       1'b0, 2'b10, 2'b10, 1'b0, 2'b00);
    step("t10_vend",    1'b0, 2'b10, 2'b00, 1'b1, 2'b01);
    step("t10_after",   1'b0, 2'b00, 2'b00, 1'b0, 2'b00);

    step("5p10_a",      1'b0, 2'b01, 2'b01, 1'b0, 2'b00);
    step("5p10_vend",   1'b0, 2'b10, 2'b00, 1'b1, 2'b00);
    step("10p5_a",      1'b0, 2'b10, 2'b10, 1'b0, 2'b00);
    step("10p5_vend",   1'b0, 2'b01, 2'b00, 1'b1, 2'b00);

    step("can5_a",      1'b0, 2'b01, 2'b01, 1'b0, 2'b00);
    step("can5_ref",    1'b0, 2'b00, 2'b00, 1'b0, 2'b01);
    step("can10_a",     1'b0, 2'b10, 2'b10, 1'b0, 2'b00);
    step("can10_ref",   1'b0, 2'b00, 2'b00, 1'b0, 2'b10);
    step("can_after",   1'b0, 2'b00, 2'b00, 1'b0, 2'b00);

    step("bad_s0",      1'b0, 2'b11, 2'b00, 1'b0, 2'b00);
    step("bad5_a",      1'b0, 2'b01, 2'b01, 1'b0, 2'b00);
    step("bad5_hold",   1'b0, 2'b11, 2'b01, 1'b0, 2'b00);
    step("bad5_hold2",  1'b0, 2'b11, 2'b01, 1'b0, 2'b00);
    step("bad5_vend",   1'b0, 2'b10, 2'b00, 1'b1, 2'b00);
    step("bad10_a",     1'b0, 2'b10, 2'b10, 1'b0, 2'b00);
    step("bad10_hold",  1'b0, 2'b11, 2'b10, 1'b0, 2'b00);
    step("bad10_ref",   1'b0, 2'b00, 2'b00, 1'b0, 2'b10);

    step("rst10_a",     1'b0, 2'b10, 2'b10, 1'b0, 2'b00);
    step("rst10_rst",   1'b1, 2'b01, 2'b00, 1'b0, 2'b00);
    step("rst10_after", 1'b0, 2'b00, 2'b00, 1'b0, 2'b00);
    step("rst5_a",      1'b0, 2'b01, 2'b01, 1'b0, 2'b00);
    step("rst5_rst",    1'b1, 2'b10, 2'b00, 1'b0, 2'b00);
    step("post_rst_5",  1'b0, 2'b01, 2'b01, 1'b0, 2'b00);
    step("post_rst_vd", 1'b0, 2'b10, 2'b00, 1'b1, 2'b00);
    step("final_idle",  1'b0, 2'b00, 2'b00, 1'b0, 2'b00);

    @(negedge clk);
    in = 2'b00;
    wait_cyc = 0;
    while (exp_q.size() != 0 && wait_cyc < 10) begin
      @(negedge clk);
      wait_cyc++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
